// File: rtl/variable_node_update_if.sv
// Message bus between a variable node and its check-node neighbourhood.
//   llr_load / llr_in                 : channel LLR load pulse and value
//   check_value_input / _enable_input : check-to-variable messages, one slot per edge
//   variable_value_output / _enable   : variable-to-check messages, same slot packing
//   hard_bit / var_done               : current hard decision and update-complete pulse
// Slot k of a packed message vector occupies bits [length*(k+1)-1 : length*k].
interface variable_node_update_if #(
  parameter int weight = 3,
  parameter int length = 15
);
  logic                     llr_load;
  logic [length-1:0]        llr_in;
  logic [weight*length-1:0] check_value_input;
  logic [weight-1:0]        check_enable_input;
  logic [weight*length-1:0] variable_value_output;
  logic [weight-1:0]        variable_enable_output;
  logic                     hard_bit;
  logic                     var_done;

  // Upstream side: drives the LLR and check messages, consumes the results.
  modport master (
    output llr_load, llr_in, check_value_input, check_enable_input,
    input  variable_value_output, variable_enable_output, hard_bit, var_done
  );

  // Variable node side.
  modport slave (
    input  llr_load, llr_in, check_value_input, check_enable_input,
    output variable_value_output, variable_enable_output, hard_bit, var_done
  );
endinterface

// File: rtl/variable_node_update.sv
// LDPC variable node: holds the channel LLR, waits for a fresh set of check
// messages, accumulates them one slot per cycle, then produces the extrinsic
// message for every check (total minus that check's own contribution,
// symmetrically saturated) one slot per cycle, followed by the hard decision.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (overrides llr_load)
//   bus  : variable_node_update_if slave modport (messages, enables, hard_bit, var_done)
module variable_node_update #(
  parameter int weight = 3,
  parameter int length = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  variable_node_update_if.slave bus
);

  localparam int jw = $clog2(weight + 1);
  localparam int sw = length + 4;  // accumulator width, cannot overflow

  // Largest magnitude produced by the saturator; the most negative code is excluded.
  localparam logic signed [sw:0] sat_hi = {6'b0, {(length - 1){1'b1}}};
  localparam logic signed [sw:0] sat_lo = -sat_hi;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_CHECK = 2'd1,
    ACCUM      = 2'd2,
    UPDATE     = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [length-1:0]        channel_q, channel_d;
  logic signed [sw-1:0]     sum_q, sum_d;
  logic [jw-1:0]            j_q, j_d;
  logic [weight-1:0]        ack_seen_q, ack_seen_d;
  logic [weight*length-1:0] out_q, out_d;
  logic [weight-1:0]        en_q, en_d;
  logic                     hard_q, hard_d;
  logic                     done_q, done_d;

  logic                     j_last;
  logic [length-1:0]        chk_slot;
  logic signed [sw:0]       diff;
  logic [length-1:0]        sat_val;

  assign j_last = (j_q == jw'(weight));

  // Check message selected by j; read straight off the bus, upstream holds it stable.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    chk_slot = '0;
    for (int k = 0; k < weight; k++) begin
      if (j_q == jw'(k)) chk_slot = bus.check_value_input[k*length +: length];
    end
  end

  // Extrinsic message: total minus this check's own contribution, then clamp.
  always_comb begin
    diff = {sum_q[sw-1], sum_q} - {{(sw + 1 - length){chk_slot[length-1]}}, chk_slot};
    if (diff > sat_hi)      sat_val = sat_hi[length-1:0];
    else if (diff < sat_lo) sat_val = sat_lo[length-1:0];
    else                    sat_val = diff[length-1:0];
  end

  always_comb begin
    state_d    = state_q;
    channel_d  = channel_q;
    sum_d      = sum_q;
    j_d        = j_q;
    ack_seen_d = ack_seen_q;
    out_d      = out_q;
    en_d       = en_q;
    hard_d     = hard_q;
    done_d     = 1'b0;  // var_done is a single-cycle pulse

    if (bus.llr_load) begin
      // A new LLR restarts the node from any state; an in-flight update is dropped.
      channel_d  = bus.llr_in;
      out_d      = {weight{bus.llr_in}};
      en_d       = '1;
      hard_d     = bus.llr_in[length-1];
      ack_seen_d = '0;
      j_d        = '0;
      state_d    = WAIT_CHECK;
    end else begin
      case (state_q)
        IDLE: begin
        end
        WAIT_CHECK: begin
          // A slot must be seen invalid once before its next valid message is
          // accepted, so stale messages from the previous round are never reused.
          for (int k = 0; k < weight; k++) begin
            if (!bus.check_enable_input[k]) begin
              ack_seen_d[k] = 1'b1;
              en_d[k]       = 1'b0;
            end
          end
          if (&ack_seen_q && &bus.check_enable_input) begin
            sum_d   = {{4{channel_q[length-1]}}, channel_q};
            j_d     = '0;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (!j_last) begin
            sum_d = sum_q + {{4{chk_slot[length-1]}}, chk_slot};
            j_d   = j_q + 1'b1;
          end else begin
            j_d     = '0;
            state_d = UPDATE;
          end
        end
        UPDATE: begin
          if (!j_last) begin
            for (int k = 0; k < weight; k++) begin
              if (j_q == jw'(k)) begin
                out_d[k*length +: length] = sat_val;
                en_d[k]                   = 1'b1;
              end
            end
            j_d = j_q + 1'b1;
          end else begin
            hard_d     = sum_q[sw-1];  // zero total decides 0
            done_d     = 1'b1;
            ack_seen_d = '0;
            j_d        = '0;
            state_d    = WAIT_CHECK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      channel_q  <= '0;
      sum_q      <= '0;
      j_q        <= '0;
      ack_seen_q <= '0;
      out_q      <= '0;
      en_q       <= '0;
      hard_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      channel_q  <= channel_d;
      sum_q      <= sum_d;
      j_q        <= j_d;
      ack_seen_q <= ack_seen_d;
      out_q      <= out_d;
      en_q       <= en_d;
      hard_q     <= hard_d;
      done_q     <= done_d;
    end
  end

  assign bus.variable_value_output  = out_q;
  assign bus.variable_enable_output = en_q;
  assign bus.hard_bit               = hard_q;
  assign bus.var_done               = done_q;

endmodule

// File: tb/tb_variable_node_update.sv
// Self-checking bench for variable_node_update (weight=3, length=15).
// A transaction-level model predicts outputs from the message arithmetic
// (sum of channel and checks, extrinsic = saturated sum minus own check);
// a compare process checks var_done every cycle and the message outputs
// whenever they are settled. Directed cases pin the model with literals.
module tb_variable_node_update;
  localparam int W    = 3;
  localparam int L    = 15;
  localparam int MAXV = 2**(L-1) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  variable_node_update_if #(.weight(W), .length(L)) bus ();

  variable_node_update #(.weight(W), .length(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  int         cyc = 0;
  bit         started = 0;
  bit         exp_valid = 0;
  int         exp_slot[W];
  logic [W-1:0] exp_en;
  int         exp_hard;
  int         done_cyc = -1;
  int         channel_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat(input int x);
    if (x > MAXV)  return MAXV;
    if (x < -MAXV) return -MAXV;
    return x;
  endfunction

  function automatic int dut_slot(input int k);
    logic signed [L-1:0] s;
    s = bus.variable_value_output[k*L +: L];
    return int'(s);
  endfunction

  function automatic int rand_val();
    return int'($urandom_range(0, 2*MAXV + 1)) - (MAXV + 1);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      check("var_done", int'(bus.var_done), (cyc == done_cyc) ? 1 : 0);
      if (exp_valid) begin
        for (int k = 0; k < W; k++) check($sformatf("slot%0d", k), dut_slot(k), exp_slot[k]);
        check("enables", int'(bus.variable_enable_output), int'(exp_en));
        check("hard_bit", int'(bus.hard_bit), exp_hard);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_model_all(input int v);
    for (int k = 0; k < W; k++) exp_slot[k] = v;
  endtask

  task automatic do_load(input int v);
    bus.llr_load = 1'b1;
    bus.llr_in   = v[L-1:0];
    tick();
    bus.llr_load = 1'b0;
    channel_m = v;
    set_model_all(v);
    exp_en    = '1;
    exp_hard  = (v < 0) ? 1 : 0;
    exp_valid = 1;
    done_cyc  = -1;
  endtask

  // Drop enables in random groups until every slot has been seen invalid,
  // then present the new messages; returns right after the node enters ACCUM.
  task automatic start_update(input int c[W]);
    logic [W-1:0] acked;
    logic [W-1:0] m;
    int           sum;
    int           tries;
    acked = '0;
    tries = 0;
    while (acked != '1) begin
      m = (tries >= 3) ? '0 : W'($urandom);
      tries++;
      bus.check_enable_input = m;
      tick();
      exp_en = exp_en & m;
      acked  = acked | ~m;
    end
    for (int k = 0; k < W; k++) bus.check_value_input[k*L +: L] = c[k][L-1:0];
    bus.check_enable_input = '1;
    tick();
    exp_valid = 0;
    done_cyc  = cyc + 2*W + 2;
    sum = channel_m;
    for (int k = 0; k < W; k++) sum += c[k];
    for (int k = 0; k < W; k++) exp_slot[k] = sat(sum - c[k]);
    exp_en   = '1;
    exp_hard = (sum < 0) ? 1 : 0;
  endtask

  task automatic finish_update();
    repeat (2*W + 2) tick();
    exp_valid = 1;
  endtask

  task automatic do_update(input int c[W]);
    start_update(c);
    finish_update();
  endtask

  task automatic lit_slots(input string name, input int v);
    for (int k = 0; k < W; k++) check(name, dut_slot(k), v);
  endtask

  // ---------------- stimulus ----------------
  int c[W];

  initial begin
    rst                    = 1'b1;
    bus.llr_load           = 1'b1;
    bus.llr_in             = 15'd123;
    bus.check_value_input  = '0;
    bus.check_enable_input = '1;
    exp_en = '0;

    // Reset wins over a simultaneous load.
    tick();
    rst          = 1'b0;
    bus.llr_load = 1'b0;
    set_model_all(0);
    exp_en    = '0;
    exp_hard  = 0;
    exp_valid = 1;
    started   = 1;
    check("rst_en", int'(bus.variable_enable_output), 0);
    check("rst_hard", int'(bus.hard_bit), 0);
    check("rst_done", int'(bus.var_done), 0);
    lit_slots("rst_slot", 0);

    // IDLE ignores check traffic until the first load.
    for (int i = 0; i < 4; i++) begin
      bus.check_enable_input = W'(i);
      tick();
    end
    bus.check_enable_input = '1;

    do_load(100);
    lit_slots("load100_slot", 100);
    check("load100_en", int'(bus.variable_enable_output), 7);
    check("load100_hard", int'(bus.hard_bit), 0);

    c = '{20, -50, 10};
    do_update(c);
    check("upd_s0", dut_slot(0), 60);
    check("upd_s1", dut_slot(1), 130);
    check("upd_s2", dut_slot(2), 70);
    check("upd_hard", int'(bus.hard_bit), 0);

    do_load(16000);
    c = '{16000, 16000, 16000};
    do_update(c);
    lit_slots("sat_pos", 16383);

    do_load(-16383);
    c = '{-16383, -16383, -16383};
    do_update(c);
    lit_slots("sat_neg", -16383);
    check("sat_neg_hard", int'(bus.hard_bit), 1);

    do_load(-5);
    c = '{1, 1, 1};
    do_update(c);
    lit_slots("neg_small", -3);
    check("neg_small_hard", int'(bus.hard_bit), 1);

    do_load(-3);
    c = '{1, 1, 1};
    do_update(c);
    lit_slots("zero_sum", -1);
    check("zero_sum_hard", int'(bus.hard_bit), 0);

    // Load during ACCUM aborts without var_done and re-arms WAIT_CHECK.
    c = '{1, 2, 3};
    start_update(c);
    tick();
    do_load(7);
    lit_slots("abort_slot", 7);
    check("abort_en", int'(bus.variable_enable_output), 7);
    repeat (10) tick();
    c = '{1, 1, 1};
    do_update(c);
    lit_slots("after_abort", 9);

    // Reset mid-UPDATE (with a concurrent load) clears everything.
    c = '{4, 5, 6};
    start_update(c);
    repeat (5) tick();
    rst          = 1'b1;
    bus.llr_load = 1'b1;
    bus.llr_in   = 15'd55;
    tick();
    rst          = 1'b0;
    bus.llr_load = 1'b0;
    channel_m = 0;
    set_model_all(0);
    exp_en    = '0;
    exp_hard  = 0;
    exp_valid = 1;
    done_cyc  = -1;
    lit_slots("midrst_slot", 0);
    for (int i = 0; i < 4; i++) begin
      bus.check_enable_input = W'($urandom);
      tick();
    end
    bus.check_enable_input = '1;

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (t == 0 || r < 4) do_load(rand_val());
      for (int k = 0; k < W; k++) c[k] = rand_val();
      if (r == 9) for (int k = 0; k < W; k++) c[k] = (t % 2 == 0) ? MAXV : -MAXV - 1;
      if (r == 8) begin
        start_update(c);
        repeat ($urandom_range(1, 7)) tick();
        do_load(rand_val());
      end else begin
        do_update(c);
      end
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
